// File: rtl/hw_stack_pkg.sv
// ---------------------------------------------------------------------------
// hw_stack_pkg
// Shared types for the hardware stack: the per-edge operation encoding and
// the decoder that turns the push/pop strobes plus the current fill state
// into exactly one operation.
// ---------------------------------------------------------------------------
package hw_stack_pkg;

    // One operation per clock edge. The two error operations leave the
    // storage and the count untouched and only raise a sticky flag.
    typedef enum logic [2:0] {
        OP_IDLE      = 3'd0,
        OP_PUSH      = 3'd1,
        OP_POP       = 3'd2,
        OP_REPLACE   = 3'd3,
        OP_OVERFLOW  = 3'd4,
        OP_UNDERFLOW = 3'd5
    } stack_op_e;

    // push+pop on a non-empty stack overwrites the top in place (this also
    // covers the full case, so a replace never overflows). push+pop on an
    // empty stack has nothing to pop, so it is an underflow and the push is
    // discarded.
    function automatic stack_op_e decode_op(
        input logic push,
        input logic pop,
        input logic is_empty,
        input logic is_full
    );
        stack_op_e op;
        case ({push, pop})
            2'b10:   op = is_full  ? OP_OVERFLOW  : OP_PUSH;
            2'b01:   op = is_empty ? OP_UNDERFLOW : OP_POP;
            2'b11:   op = is_empty ? OP_UNDERFLOW : OP_REPLACE;
            default: op = OP_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/hw_stack_if.sv
// ---------------------------------------------------------------------------
// hw_stack_if
// Control/data bundle between the control unit / datapath and the stack.
//   master (control unit + datapath): drives push, pop, data_in, clr_err;
//                                     observes data_out, count, empty, full,
//                                     overflow, underflow.
//   slave  (hw_stack):                the mirror image.
// WIDTH and DEPTH must match the hw_stack instance attached to it.
// ---------------------------------------------------------------------------
interface hw_stack_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic             clr_err;
    logic [WIDTH-1:0] data_out;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, data_in, clr_err,
        input  data_out, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, data_in, clr_err,
        output data_out, count, empty, full, overflow, underflow
    );

endinterface

// File: rtl/stack_ram.sv
// ---------------------------------------------------------------------------
// stack_ram
// WIDTH x DEPTH storage for hw_stack: one synchronous write port, one
// asynchronous read port.
//   clk    in  rising-edge clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out read data, combinational from raddr
// ---------------------------------------------------------------------------
module stack_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; the stack's count alone decides which
    // entries are valid, so clearing storage would only cost logic and keep
    // it out of plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/hw_stack.sv
// ---------------------------------------------------------------------------
// hw_stack
// Parametrised LIFO for the CPU call/return and data-stack path. The stack
// pointer is internal: the control unit only strobes push/pop, and the top
// of stack is always visible on data_out.
//   clk    in  rising-edge clock
//   reset  in  synchronous, active-high; overrides every other input
//   bus    slave side of hw_stack_if:
//          push, pop, data_in, clr_err  in
//          data_out  top of stack, 0 when empty
//          count     valid entries, 0..DEPTH
//          empty     count == 0
//          full      count == DEPTH
//          overflow  sticky, push rejected while full
//          underflow sticky, pop rejected while empty
// ---------------------------------------------------------------------------
module hw_stack
    import hw_stack_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input logic      clk,
    input logic      reset,
    hw_stack_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]    count_q;
    logic             overflow_q;
    logic             underflow_q;

    logic             is_empty;
    logic             is_full;
    stack_op_e        op;

    logic [CW-1:0]    top_idx;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] rdata;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));
    assign top_idx  = count_q - CW'(1);

    assign op = decode_op(bus.push, bus.pop, is_empty, is_full);

    // NOTE: every signal written here gets a value on every path, so the
    // block stays purely combinational and no latch is inferred.
    always_comb begin
        we    = 1'b0;
        waddr = AW'(count_q);
        if (!reset) begin
            case (op)
                OP_PUSH: begin
                    we    = 1'b1;
                    waddr = AW'(count_q);
                end
                OP_REPLACE: begin
                    we    = 1'b1;
                    waddr = AW'(top_idx);
                end
                default: ;
            endcase
        end
    end

    // When empty the read address is parked at 0 so it never leaves the
    // array for non-power-of-two depths; the word is masked off anyway.
    assign raddr = is_empty ? '0 : AW'(top_idx);

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (bus.data_in),
        .raddr (raddr),
        .rdata (rdata)
    );

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            case (op)
                OP_PUSH: count_q <= count_q + CW'(1);
                OP_POP:  count_q <= top_idx;
                default: ;
            endcase
            // clr_err drops the old flag, but a fresh error in the same
            // cycle still sets it.
            overflow_q  <= (op == OP_OVERFLOW)  | (overflow_q  & ~bus.clr_err);
            underflow_q <= (op == OP_UNDERFLOW) | (underflow_q & ~bus.clr_err);
        end
    end

    assign bus.data_out  = is_empty ? '0 : rdata;
    assign bus.count     = count_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule
